div_seq: RTL

//  Iterative signed restoring divider: inverse of the ALU adder/multiplier path; reuses CLA-style subtraction per step.

---
 rtl/div_seq_pkg.sv | 34 +++
 rtl/div_seq_sub_step.sv | 30 +++
 rtl/div_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the div_seq iterative divider: FSM state encoding,
// counter sizing and the 8-bit carry-lookahead slice used for subtraction and negation.
package div_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } div_state_e;

  // Counter must hold 0..WIDTH, one bit beyond the last step index.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // 8-bit slice: carries from generate/propagate terms; returns {cout, sum}.
  function automatic logic [8:0] cla_8(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

endpackage

// File: rtl/div_seq_sub_step.sv
// One restoring-division step: (WIDTH+1)-bit minuend minus zero-extended divisor magnitude,
// built from cla_8 slices with inverted subtrahend and carry-in of 1.
module div_seq_sub_step
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned NSLICE = WIDTH / 8;

  logic [NSLICE:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    logic [8:0] r;
    assign r                = cla_8(minuend[8*i +: 8], ~subtrahend[8*i +: 8], carry[i]);
    assign diff[8*i +: 8]   = r[7:0];
    assign carry[i+1]       = r[8];
  end

  // Top bit pairs the minuend MSB with the inverted zero extension (a 1); no carry out means negative.
  assign borrow = ~(minuend[WIDTH] | carry[NSLICE]);

endmodule

// File: rtl/div_seq.sv
// Iterative signed restoring divider, one quotient bit per clock, with divide-by-zero/overflow flag.
// Optional remainder output port enabled by defining DIV_REMAINDER_EN.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             result_rdy
);

  localparam int unsigned    CNT_W   = div_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [WIDTH-1:0] q, q_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] absb, absb_d;
  logic             sign_q, sign_q_d;
  logic             ovf, ovf_d;
  logic             busy_d;
  logic [WIDTH-1:0] result_d;
  logic             exception_d;
  logic             result_rdy_d;
`ifdef DIV_REMAINDER_EN
  logic             sign_r, sign_r_d;
  logic [WIDTH-1:0] remainder_d;
`endif

  logic [WIDTH-1:0] step_diff;
  logic             step_borrow;

  // Two's complement negation through the same lookahead slices: ~x + 0 + 1.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] s;
    logic [8:0]       r;
    logic             c;
    c = 1'b1;
    for (int i = 0; i < int'(WIDTH / 8); i++) begin
      r          = cla_8(~x[8*i +: 8], 8'h00, c);
      s[8*i +: 8] = r[7:0];
      c          = r[8];
    end
    return s;
  endfunction

  div_seq_sub_step #(.WIDTH(WIDTH)) u_step (
    .minuend    ({rem, q[WIDTH-1]}),
    .subtrahend (absb),
    .diff       (step_diff),
    .borrow     (step_borrow)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d      = state;
    count_d      = count;
    q_d          = q;
    rem_d        = rem;
    absb_d       = absb;
    sign_q_d     = sign_q;
    ovf_d        = ovf;
    busy_d       = busy;
    result_d     = result;
    exception_d  = exception;
    result_rdy_d = 1'b0;
`ifdef DIV_REMAINDER_EN
    sign_r_d     = sign_r;
    remainder_d  = remainder;
`endif

    unique case (state)
      ST_IDLE: begin
        // The result_rdy cycle still belongs to the previous operation.
        if (start && !result_rdy) begin
          busy_d   = 1'b1;
          count_d  = '0;
          rem_d    = '0;
          q_d      = dividend[WIDTH-1] ? negate(dividend) : dividend;
          absb_d   = divisor[WIDTH-1] ? negate(divisor) : divisor;
          sign_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          ovf_d    = (dividend == INT_MIN) && (divisor == '1);
`ifdef DIV_REMAINDER_EN
          sign_r_d = dividend[WIDTH-1];
`endif
          state_d  = (divisor == '0) ? ST_ZERO : ST_RUN;
        end
      end

      ST_RUN: begin
        q_d     = {q[WIDTH-2:0], ~step_borrow};
        rem_d   = step_borrow ? {rem[WIDTH-2:0], q[WIDTH-1]} : step_diff;
        count_d = count + CNT_W'(1);
        if (count == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        result_d     = sign_q ? negate(q) : q;
        exception_d  = ovf;
`ifdef DIV_REMAINDER_EN
        remainder_d  = sign_r ? negate(rem) : rem;
`endif
        result_rdy_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end

      ST_ZERO: begin
        result_d     = '0;
        exception_d  = 1'b1;
`ifdef DIV_REMAINDER_EN
        remainder_d  = '0;
`endif
        result_rdy_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      q          <= '0;
      rem        <= '0;
      absb       <= '0;
      sign_q     <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r     <= 1'b0;
      remainder  <= '0;
`endif
    end else begin
      state      <= state_d;
      count      <= count_d;
      q          <= q_d;
      rem        <= rem_d;
      absb       <= absb_d;
      sign_q     <= sign_q_d;
      ovf        <= ovf_d;
      busy       <= busy_d;
      result     <= result_d;
      exception  <= exception_d;
      result_rdy <= result_rdy_d;
`ifdef DIV_REMAINDER_EN
      sign_r     <= sign_r_d;
      remainder  <= remainder_d;
`endif
    end
  end

endmodule
